// File: rtl/gray_window_processor.sv
// 3x3 gray-level window processor: bypass, erode (min), dilate (max) or threshold.
// Every mode has the same 3-clock latency from per_* inputs to post_* outputs.
module gray_window_processor #(
  parameter logic [10:0] IMG_HDISP    = 11'd640,
  parameter logic [10:0] IMG_VDISP    = 11'd480,
  parameter int          DW           = 8,
  parameter logic [1:0]  DEFAULT_MODE = 2'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic [DW-1:0] per_img_Gray,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] threshold,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic [DW-1:0] post_img_Gray,
  output logic [1:0]    mode_active
);

  localparam int AW = (IMG_HDISP > 11'd1) ? $clog2(IMG_HDISP) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  if (IMG_HDISP < 11'd3 || IMG_VDISP < 11'd3) begin : g_geometry_check
    $error("gray_window_processor: frame must be at least 3x3 pixels");
  end

  function automatic logic [DW-1:0] umin(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t             state_q, state_d;
  logic               vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  logic [10:0]        col_q, col_d, row_q, row_d;
  logic [1:0]         mode_active_q, mode_active_d;
  logic [DW-1:0]      th_active_q, th_active_d;
  logic               vs1_q, vs1_d, hr1_q, hr1_d;
  logic [DW-1:0]      pix1_q, pix1_d, top1_q, top1_d, mid1_q, mid1_d;
  logic [10:0]        col1_q, col1_d, row1_q, row1_d;
  logic               vs2_q, vs2_d, hr2_q, hr2_d;
  logic [DW-1:0]      pix2_q, pix2_d;
  logic [10:0]        col2_q, col2_d, row2_q, row2_d;
  logic [2:0][DW-1:0] wc0_q, wc0_d, wc1_q, wc1_d, wc2_q, wc2_d;
  logic               vs3_q, vs3_d, hr3_q, hr3_d;
  logic [DW-1:0]      gray3_q, gray3_d;

  logic [DW-1:0]      lb1_q [0:IMG_HDISP-1];
  logic [DW-1:0]      lb2_q [0:IMG_HDISP-1];

  logic               vs_rise_s, hr_fall_s, col_in_s, lb_we_s, mask_s;
  logic [AW-1:0]      rd_idx_s;
  logic [8:0][DW-1:0] win_s;
  logic [DW-1:0]      win_min_s, win_max_s, filt_s;

  // Next-state logic for counters, frame arming, the 3-stage pipeline and the window.
  always_comb begin
    vs_rise_s = per_frame_vsync & ~vs_prev_q;
    hr_fall_s = ~per_frame_href & hr_prev_q;
    col_in_s  = (col_q < IMG_HDISP);
    lb_we_s   = per_frame_href & col_in_s;
    rd_idx_s  = col_in_s ? col_q[AW-1:0] : {AW{1'b0}};

    vs_prev_d = per_frame_vsync;
    hr_prev_d = per_frame_href;
    state_d   = vs_rise_s ? ACTIVE : state_q;

    if (per_frame_href) begin
      col_d = col_in_s ? (col_q + 11'd1) : col_q;
    end else if (hr_fall_s) begin
      col_d = 11'd0;
    end else begin
      col_d = col_q;
    end

    if (vs_rise_s) begin
      row_d = 11'd0;
    end else if (hr_fall_s && (row_q != 11'h7FF)) begin
      row_d = row_q + 11'd1;
    end else begin
      row_d = row_q;
    end

    mode_active_d = vs_rise_s ? mode      : mode_active_q;
    th_active_d   = vs_rise_s ? threshold : th_active_q;

    // Stage 1: new window column {bottom=current line, middle=r-1, top=r-2}.
    vs1_d  = per_frame_vsync;
    hr1_d  = per_frame_href;
    pix1_d = per_img_Gray;
    top1_d = lb2_q[rd_idx_s];
    mid1_d = lb1_q[rd_idx_s];
    col1_d = col_q;
    row1_d = row_q;

    // Stage 2: the window only shifts on real pixels, so blanking leaves it intact.
    vs2_d  = vs1_q;
    hr2_d  = hr1_q;
    pix2_d = pix1_q;
    col2_d = col1_q;
    row2_d = row1_q;
    if (hr1_q) begin
      wc0_d = {pix1_q, mid1_q, top1_q};
      wc1_d = wc0_q;
      wc2_d = wc1_q;
    end else begin
      wc0_d = wc0_q;
      wc1_d = wc1_q;
      wc2_d = wc2_q;
    end

    // Stage 3: filter the window held in stage 2.
    win_s     = {wc2_q, wc1_q, wc0_q};
    win_min_s = win_s[0];
    win_max_s = win_s[0];
    for (logic [3:0] i = 4'd1; i < 4'd9; i = i + 4'd1) begin
      win_min_s = umin(win_min_s, win_s[i]);
      win_max_s = umax(win_max_s, win_s[i]);
    end
    mask_s = (row2_q < 11'd2) || (col2_q < 11'd2) || (col2_q >= IMG_HDISP);

    case (mode_active_q)
      2'd0:    filt_s = pix2_q;
      2'd1:    filt_s = mask_s ? {DW{1'b0}} : win_min_s;
      2'd2:    filt_s = mask_s ? {DW{1'b0}} : win_max_s;
      2'd3:    filt_s = (mask_s || (wc1_q[1] < th_active_q)) ? {DW{1'b0}} : {DW{1'b1}};
      default: filt_s = pix2_q;
    endcase

    if (state_q == ACTIVE) begin
      vs3_d   = vs2_q;
      hr3_d   = hr2_q;
      gray3_d = hr2_q ? filt_s : {DW{1'b0}};
    end else begin
      vs3_d   = 1'b0;
      hr3_d   = 1'b0;
      gray3_d = {DW{1'b0}};
    end
  end

  // Control, pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      // Edge detector starts high: a frame already in progress at reset release is not a rise.
      vs_prev_q     <= 1'b1;
      hr_prev_q     <= 1'b0;
      col_q         <= 11'd0;
      row_q         <= 11'd0;
      mode_active_q <= DEFAULT_MODE;
      th_active_q   <= {DW{1'b0}};
      vs1_q         <= 1'b0;
      hr1_q         <= 1'b0;
      pix1_q        <= {DW{1'b0}};
      top1_q        <= {DW{1'b0}};
      mid1_q        <= {DW{1'b0}};
      col1_q        <= 11'd0;
      row1_q        <= 11'd0;
      vs2_q         <= 1'b0;
      hr2_q         <= 1'b0;
      pix2_q        <= {DW{1'b0}};
      col2_q        <= 11'd0;
      row2_q        <= 11'd0;
      wc0_q         <= '0;
      wc1_q         <= '0;
      wc2_q         <= '0;
      vs3_q         <= 1'b0;
      hr3_q         <= 1'b0;
      gray3_q       <= {DW{1'b0}};
    end else begin
      state_q       <= state_d;
      vs_prev_q     <= vs_prev_d;
      hr_prev_q     <= hr_prev_d;
      col_q         <= col_d;
      row_q         <= row_d;
      mode_active_q <= mode_active_d;
      th_active_q   <= th_active_d;
      vs1_q         <= vs1_d;
      hr1_q         <= hr1_d;
      pix1_q        <= pix1_d;
      top1_q        <= top1_d;
      mid1_q        <= mid1_d;
      col1_q        <= col1_d;
      row1_q        <= row1_d;
      vs2_q         <= vs2_d;
      hr2_q         <= hr2_d;
      pix2_q        <= pix2_d;
      col2_q        <= col2_d;
      row2_q        <= row2_d;
      wc0_q         <= wc0_d;
      wc1_q         <= wc1_d;
      wc2_q         <= wc2_d;
      vs3_q         <= vs3_d;
      hr3_q         <= hr3_d;
      gray3_q       <= gray3_d;
    end
  end

  // Line buffers (not reset): each column slot shifts down one line per written pixel.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lb2_q[rd_idx_s] <= lb1_q[rd_idx_s];
      lb1_q[rd_idx_s] <= per_img_Gray;
    end
  end

  assign post_frame_vsync = vs3_q;
  assign post_frame_href  = hr3_q;
  assign post_img_Gray    = gray3_q;
  assign mode_active      = mode_active_q;

endmodule

// File: tb/tb_gray_window_processor.sv
// Bench for gray_window_processor: image-array reference model checked every cycle,
// plus a table of probe points for the directed window/border/threshold cases.
module tb_gray_window_processor;

  localparam logic [10:0] H   = 11'd8;
  localparam logic [10:0] V   = 11'd6;
  localparam logic [1:0]  DEF = 2'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs_i = 1'b0, hr_i = 1'b0;
  logic [7:0] pix_i = 8'd0, th_i = 8'd0;
  logic [1:0] md_i = 2'd0;
  logic       post_vs, post_hr;
  logic [7:0] post_g;
  logic [1:0] mode_act;

  gray_window_processor #(.IMG_HDISP(H), .IMG_VDISP(V), .DW(8), .DEFAULT_MODE(DEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs_i), .per_frame_href(hr_i), .per_img_Gray(pix_i),
    .mode(md_i), .threshold(th_i),
    .post_frame_vsync(post_vs), .post_frame_href(post_hr), .post_img_Gray(post_g),
    .mode_active(mode_act)
  );

  always #5 clk = ~clk;

  typedef struct {logic vs; logic hr; logic [7:0] g; logic cap; int r; int c;} exp_t;
  typedef struct {logic [1:0] md; logic [7:0] th; logic [7:0] bg; logic [7:0] spot;
                  int pr; int pc; logic [7:0] exp;} vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: the frame as a 2-D image plus frame-level state.
  logic [7:0] img [0:15][0:7];
  logic [7:0] cap [0:15][0:7];
  logic       m_active, m_prev_vs, m_prev_hr;
  logic [1:0] m_mode;
  logic [7:0] m_th;
  int         m_row, m_col;

  function automatic exp_t zero_exp();
    exp_t e;
    e.vs = 1'b0; e.hr = 1'b0; e.g = 8'd0; e.cap = 1'b0; e.r = 0; e.c = 0;
    return e;
  endfunction

  function automatic logic [7:0] ref_pixel(int r, int c, logic [7:0] p);
    int mn, mx, v;
    if (m_mode == 2'd0) return p;
    if (r < 2 || c < 2 || c >= 8) return 8'd0;
    mn = 255; mx = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v = int'(img[r-dr][c-dc]);
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
    if (m_mode == 2'd1) return 8'(mn);
    if (m_mode == 2'd2) return 8'(mx);
    return (img[r-1][c-1] >= m_th) ? 8'd255 : 8'd0;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_prev_vs = 1'b1; m_prev_hr = 1'b0;
    m_mode = DEF; m_th = 8'd0; m_row = 0; m_col = 0;
    q.delete();
    q.push_back(zero_exp());
    q.push_back(zero_exp());
  endtask

  task automatic model_step();
    exp_t e;
    if (vs_i && !m_prev_vs) begin
      m_active = 1'b1; m_mode = md_i; m_th = th_i; m_row = 0;
    end
    e = zero_exp();
    e.r = m_row; e.c = m_col;
    if (hr_i && m_col < 8 && m_row < 16) img[m_row][m_col] = pix_i;
    if (m_active) begin
      e.vs = vs_i; e.hr = hr_i;
      if (hr_i) begin
        e.cap = 1'b1;
        e.g = ref_pixel(m_row, m_col, pix_i);
      end
    end
    if (hr_i) begin
      if (m_col < 8) m_col++;
    end else if (m_prev_hr) begin
      m_col = 0;
      if (m_row < 2047) m_row++;
    end
    m_prev_vs = vs_i; m_prev_hr = hr_i;
    q.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    e = q.pop_front();
    tests++;
    if (post_vs !== e.vs || post_hr !== e.hr || post_g !== e.g || mode_act !== m_mode) begin
      fails++;
      $display("FAIL cycle t=%0t row=%0d col=%0d: got vs=%b hr=%b g=%0d mode=%0d, expected vs=%b hr=%b g=%0d mode=%0d",
               $time, e.r, e.c, post_vs, post_hr, post_g, mode_act, e.vs, e.hr, e.g, m_mode);
    end
    if (e.cap && e.r < 16 && e.c < 8) cap[e.r][e.c] = post_g;
  endtask

  task automatic cycle(input logic v, input logic h, input logic [7:0] p);
    vs_i = v; hr_i = h; pix_i = p;
    model_step();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic do_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (post_vs !== 1'b0 || post_hr !== 1'b0 || post_g !== 8'd0 || mode_act !== DEF) begin
      fails++;
      $display("FAIL async_reset: got vs=%b hr=%b g=%0d mode=%0d, expected 0 0 0 %0d",
               post_vs, post_hr, post_g, mode_act, DEF);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [7:0] src_pix(int kind, logic [7:0] bg, logic [7:0] spot, int r, int c);
    if (kind == 1) return 8'(r * 8 + c);
    if (kind == 2) return (r == 2 && c == 3) ? spot : bg;
    return 8'($urandom);
  endfunction

  // kind: 0 random, 1 raster ramp, 2 background with one spot at (2,3).
  task automatic run_frame(input int kind, input logic [1:0] fmode, input logic [7:0] fth,
                           input logic [7:0] bg, input logic [7:0] spot,
                           input int chg_line, input logic [1:0] chg_mode, input int rst_line);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) cap[r][c] = 8'hxx;
    md_i = fmode ^ 2'd3; th_i = ~fth;
    repeat (3) cycle(1'b0, 1'b0, 8'd0);
    md_i = fmode; th_i = fth;
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 8'd0);
    for (int r = 0; r < 6; r++) begin
      if (r == chg_line) begin md_i = chg_mode; th_i = 8'($urandom); end
      for (int c = 0; c < 8; c++) begin
        cycle(1'b1, 1'b1, src_pix(kind, bg, spot, r, c));
        if (r == rst_line && c == 3) do_reset_mid();
      end
      repeat ($urandom_range(1, 5)) cycle(1'b1, 1'b0, 8'd0);
    end
    cycle(1'b1, 1'b0, 8'd0);
    repeat (3) cycle(1'b0, 1'b0, 8'd0);
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = '{2'd1, 8'd0,   8'd200, 8'd10,  1, 2, 8'd10};
    vt[1]  = '{2'd1, 8'd0,   8'd200, 8'd10,  3, 4, 8'd10};
    vt[2]  = '{2'd1, 8'd0,   8'd200, 8'd10,  1, 5, 8'd200};
    vt[3]  = '{2'd1, 8'd0,   8'd200, 8'd10,  0, 3, 8'd0};
    vt[4]  = '{2'd1, 8'd0,   8'd200, 8'd10,  4, 3, 8'd200};
    vt[5]  = '{2'd1, 8'd0,   8'd200, 8'd10,  2, 0, 8'd0};
    vt[6]  = '{2'd2, 8'd0,   8'd0,   8'd250, 2, 3, 8'd250};
    vt[7]  = '{2'd2, 8'd0,   8'd0,   8'd250, 3, 2, 8'd250};
    vt[8]  = '{2'd2, 8'd0,   8'd0,   8'd250, 4, 4, 8'd0};
    vt[9]  = '{2'd3, 8'd128, 8'd0,   8'd127, 2, 3, 8'd0};
    vt[10] = '{2'd3, 8'd128, 8'd0,   8'd128, 2, 3, 8'd255};
    vt[11] = '{2'd0, 8'd0,   8'd77,  8'd5,   1, 2, 8'd5};
    vt[12] = '{2'd3, 8'd128, 8'd200, 8'd127, 2, 2, 8'd255};
    vt[13] = '{2'd1, 8'd0,   8'd200, 8'd10,  1, 6, 8'd200};

    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (post_vs !== 1'b0 || post_hr !== 1'b0 || post_g !== 8'd0 || mode_act !== DEF) begin
      fails++;
      $display("FAIL reset_state: got vs=%b hr=%b g=%0d mode=%0d, expected 0 0 0 %0d",
               post_vs, post_hr, post_g, mode_act, DEF);
    end
    rst_n = 1'b1;
    model_reset();

    // Raster ramp in bypass.
    run_frame(1, 2'd0, 8'd0, 8'd0, 8'd0, -1, 2'd0, -1);

    // Directed probe table (probe coordinates are window centres; mode 0 probes the input pixel).
    for (int i = 0; i < 14; i++) begin
      run_frame(2, vt[i].md, vt[i].th, vt[i].bg, vt[i].spot, -1, 2'd0, -1);
      tests++;
      if (cap[vt[i].pr + 1][vt[i].pc + 1] !== vt[i].exp) begin
        fails++;
        $display("FAIL probe[%0d] mode=%0d centre=(%0d,%0d): got %0d, expected %0d",
                 i, vt[i].md, vt[i].pr, vt[i].pc, cap[vt[i].pr + 1][vt[i].pc + 1], vt[i].exp);
      end
    end

    // Mid-frame mode change must wait for the next frame.
    run_frame(0, 2'd0, 8'd0, 8'd0, 8'd0, 3, 2'd2, -1);
    run_frame(0, 2'd2, 8'd0, 8'd0, 8'd0, -1, 2'd0, -1);

    // Reset mid-line, then a normal frame.
    run_frame(0, 2'd1, 8'd0, 8'd0, 8'd0, -1, 2'd0, 2);
    run_frame(0, 2'd3, 8'd100, 8'd0, 8'd0, -1, 2'd0, -1);

    repeat (12)
      run_frame(0, 2'($urandom_range(0, 3)), 8'($urandom), 8'd0, 8'd0,
                $urandom_range(0, 7), 2'($urandom_range(0, 3)), -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
